svc_axi_mem_ro_lat: RTL

// - Read-only AXI4 slave memory model with programmable first-beat latency, queued

---
 rtl/svc_axi_mem_ro_lat.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/svc_axi_mem_ro_lat.sv
// svc_axi_mem_ro_lat
// Read-only AXI4 slave memory model. Read requests are queued in an AR FIFO,
// then served strictly in order. The first beat of each burst appears
// RD_LATENCY idle cycles after the request leaves the queue. FIXED, INCR and
// WRAP bursts are supported. Unsupported requests are answered with SLVERR
// beats that carry zero data. The 'mem' array is never reset or written by
// this block; benches preload it hierarchically.
//
// Optional feature: define SVC_AXI_MEM_RO_STALL_EN to insert pseudo-random
// R-channel bubbles from a 16-bit LFSR seeded with STALL_SEED.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   s_axi_ar*           AR channel (valid/ready, id, addr, len, size, burst)
//   s_axi_r*            R channel (valid/ready, id, data, resp, last)
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// Once raised, rvalid stays high with rid/rdata/rresp/rlast stable until
// that transfer. arvalid is never required to wait for arready.
//
// FSM state is visible on the internal signal 'state' (IDLE/WAIT/BURST).
module svc_axi_mem_ro_lat #(
  parameter int          AXI_ADDR_WIDTH = 16,
  parameter int          AXI_DATA_WIDTH = 128,
  parameter int          AXI_ID_WIDTH   = 4,
  parameter int          RD_LATENCY     = 4,
  parameter int          OUTSTANDING    = 4,
  parameter logic [15:0] STALL_SEED     = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_axi_arvalid,
  input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  output logic                      s_axi_arready,
  output logic                      s_axi_rvalid,
  output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  input  logic                      s_axi_rready
);

  localparam int AW    = AXI_ADDR_WIDTH;
  localparam int OFFW  = $clog2(AXI_DATA_WIDTH / 8);
  localparam int DEPTH = (2 ** AW) / (AXI_DATA_WIDTH / 8);
  localparam int QW    = $clog2(OUTSTANDING);
  localparam int LW    = $clog2(RD_LATENCY + 2);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0] id;
    logic [AW-1:0]           addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } ar_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

  // AR queue
  ar_t           q_mem [OUTSTANDING];
  logic [QW-1:0] wr_ptr, rd_ptr;
  logic [QW:0]   q_count;
  logic          full, empty, push, pop;
  ar_t           head;
  logic          head_err;

  // Engine
  state_t          state;
  logic [LW-1:0]   lat_cnt;
  logic [AW-1:0]   e_addr;
  logic [7:0]      e_len;
  logic [2:0]      e_size;
  logic [1:0]      e_burst;
  logic            e_err;
  logic [7:0]      beat;
  logic [AW-1:0]   next_addr;
  logic [AW-OFFW-1:0] rd_idx;
  logic            rd_err;
  logic [AXI_DATA_WIDTH-1:0] rd_word;
  logic            last_hs;
  logic            stall_now;

  function automatic logic is_err(input logic [7:0] len, input logic [2:0] size,
                                  input logic [1:0] burst);
    logic bad_wrap;
    bad_wrap = (burst == BURST_WRAP) &&
               !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (burst == 2'b11) || bad_wrap || (int'(size) > OFFW);
  endfunction

  // WRAP keeps the upper address bits of the aligned (len+1)*2**size window
  // and lets only the bits inside the window increment.
  function automatic logic [AW-1:0] advance(input logic [AW-1:0] addr,
                                            input logic [7:0] len,
                                            input logic [2:0] size,
                                            input logic [1:0] burst);
    logic [AW-1:0] step, mask, sum, res;
    step = AW'(1) << size;
    mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
    sum  = addr + step;
    case (burst)
      BURST_FIXED: res = addr;
      BURST_WRAP:  res = (addr & ~mask) | (sum & mask);
      default:     res = sum;
    endcase
    return res;
  endfunction

  assign full          = (q_count == (QW + 1)'(OUTSTANDING));
  assign empty         = (q_count == '0);
  assign s_axi_arready = rst_n && !full;
  assign push          = s_axi_arvalid && s_axi_arready;
  assign head          = q_mem[rd_ptr];
  assign head_err      = is_err(head.len, head.size, head.burst);

  assign last_hs = (state == S_BURST) && s_axi_rvalid && s_axi_rready && (beat == e_len);
  // Popping on the final handshake avoids a dead IDLE cycle between bursts.
  assign pop     = !empty && ((state == S_IDLE) || last_hs);

  assign next_addr = advance(e_addr, e_len, e_size, e_burst);

  // Single read port: the word loaded into rdata at the next edge.
  always_comb begin
    rd_idx = next_addr[AW-1:OFFW];
    rd_err = e_err;
    if (pop) begin
      rd_idx = head.addr[AW-1:OFFW];
      rd_err = head_err;
    end else if (state == S_WAIT) begin
      rd_idx = e_addr[AW-1:OFFW];
    end
  end

  assign rd_word = rd_err ? '0 : mem[rd_idx];

  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wr_ptr] <= '{id: s_axi_arid, addr: s_axi_araddr, len: s_axi_arlen,
                         size: s_axi_arsize, burst: s_axi_arburst};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef SVC_AXI_MEM_RO_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= STALL_SEED;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall_now = (lfsr[1:0] == 2'b00);
`else
  logic [15:0] unused_seed;
  assign unused_seed = STALL_SEED;
  assign stall_now   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      lat_cnt      <= '0;
      e_addr       <= '0;
      e_len        <= '0;
      e_size       <= '0;
      e_burst      <= '0;
      e_err        <= 1'b0;
      beat         <= '0;
      s_axi_rvalid <= 1'b0;
      s_axi_rid    <= '0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= '0;
      s_axi_rlast  <= 1'b0;
    end else if (pop) begin
      e_addr      <= head.addr;
      e_len       <= head.len;
      e_size      <= head.size;
      e_burst     <= head.burst;
      e_err       <= head_err;
      beat        <= '0;
      s_axi_rid   <= head.id;
      s_axi_rresp <= head_err ? RESP_SLVERR : RESP_OKAY;
      if (RD_LATENCY == 0) begin
        state        <= S_BURST;
        s_axi_rvalid <= !stall_now;
        s_axi_rdata  <= rd_word;
        s_axi_rlast  <= (head.len == 8'd0);
      end else begin
        state        <= S_WAIT;
        lat_cnt      <= LW'(RD_LATENCY);
        s_axi_rvalid <= 1'b0;
        s_axi_rlast  <= 1'b0;
      end
    end else begin
      case (state)
        S_WAIT: begin
          // Loaded with RD_LATENCY, so WAIT lasts exactly RD_LATENCY cycles.
          if (lat_cnt == LW'(1)) begin
            state        <= S_BURST;
            s_axi_rvalid <= !stall_now;
            s_axi_rdata  <= rd_word;
            s_axi_rlast  <= (e_len == 8'd0);
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        S_BURST: begin
          if (!s_axi_rvalid) begin
            // Beat already loaded; only reachable when a stall bubble was inserted.
            s_axi_rvalid <= !stall_now;
          end else if (s_axi_rready) begin
            if (beat == e_len) begin
              state        <= S_IDLE;
              s_axi_rvalid <= 1'b0;
              s_axi_rlast  <= 1'b0;
            end else begin
              beat         <= beat + 8'd1;
              e_addr       <= next_addr;
              s_axi_rdata  <= rd_word;
              s_axi_rlast  <= ((beat + 8'd1) == e_len);
              s_axi_rvalid <= !stall_now;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
